rx_wr_arbiter: RTL and testbench

//  Shares one downstream write port (the async FIFO into the HDMI clock domain) between the

---
 rtl/rx_wr_arbiter_pkg.sv | 25 ++
 rtl/rx_wr_arbiter_if.sv | 28 ++
 rtl/rx_arb_fifo.sv | 42 ++++
 rtl/rx_wr_arbiter.sv | 109 ++++++++++
 tb/tb_rx_wr_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rx_wr_arbiter_pkg.sv
// Shared definitions for the GMII receive write arbiter: output word tags,
// payload field widths and a saturating add used by the drop counter.
package rx_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    TAG_VID = 2'b00,
    TAG_AUX = 2'b01,
    TAG_EOP = 2'b10,
    TAG_RSV = 2'b11
  } tag_e;

  localparam int unsigned VID_W     = 29;
  localparam int unsigned AUX_W     = 12;
  localparam int unsigned PAYLOAD_W = 30;
  localparam int unsigned PKT_CNT_W = 11;
  localparam int unsigned DROP_W    = 8;
  localparam int unsigned VQ_W      = VID_W + 1;  // {is_eop, data}

  function automatic logic [DROP_W-1:0] sat_add(logic [DROP_W-1:0] a, logic [1:0] n);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W - 1){1'b0}}, n};
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/rx_wr_arbiter_if.sv
// Bundle of the arbiter's data-path signals.
//  slave  : arbiter side (parser streams and fifo_full in; fifo write port and status out)
//  master : environment side (drives parser streams and fifo_full)
interface rx_wr_arbiter_if;
  import rx_wr_arbiter_pkg::*;

  logic               arb_en;
  logic [VID_W-1:0]   vid_data;
  logic               vid_valid;
  logic               packet_en;
  logic [AUX_W-1:0]   aux_data;
  logic               aux_valid;
  logic               fifo_full;
  logic [31:0]        fifo_din;
  logic               fifo_wr_en;
  logic [DROP_W-1:0]  drop_cnt;
  logic               overflow;

  modport slave (
    input  arb_en, vid_data, vid_valid, packet_en, aux_data, aux_valid, fifo_full,
    output fifo_din, fifo_wr_en, drop_cnt, overflow
  );

  modport master (
    output arb_en, vid_data, vid_valid, packet_en, aux_data, aux_valid, fifo_full,
    input  fifo_din, fifo_wr_en, drop_cnt, overflow
  );
endinterface

// File: rtl/rx_arb_fifo.sv
// Small synchronous show-ahead queue.
//  clk, rst_n   : clock, asynchronous active-low reset (empties the queue)
//  push, wdata  : write; ignored while full
//  pop, rdata   : rdata is the head entry; pop ignored while empty
//  full, empty  : status from an extra-bit pointer compare
module rx_arb_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rx_wr_arbiter.sv
// Shares the downstream clock-crossing FIFO write port between the video
// word stream and the aux/audio stream of the GMII receive path. Each source
// is buffered in its own queue; an end-of-packet marker carrying the packet's
// word count is queued behind each video packet. Output is tagged and
// registered one cycle after the grant.
//  clk125, sys_rst_n : receive clock, asynchronous active-low reset
//  bus (slave)       : parser streams, arb_en, fifo_full in;
//                      fifo_din/fifo_wr_en, drop_cnt, overflow out
module rx_wr_arbiter
  import rx_wr_arbiter_pkg::*;
#(
  parameter int unsigned VQ_AW       = 3,
  parameter int unsigned AQ_AW       = 4,
  parameter int unsigned MAX_VID_RUN = 4
) (
  input  logic            clk125,
  input  logic            sys_rst_n,
  rx_wr_arbiter_if.slave  bus
);

  localparam int unsigned      RUN_W   = $clog2(MAX_VID_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);

  logic                 pkt_en_q;
  logic                 eop_pend;
  logic [PKT_CNT_W-1:0] pkt_words;
  logic [RUN_W-1:0]     vid_run;

  logic                 vq_full, vq_empty, aq_full, aq_empty;
  logic [VQ_W-1:0]      vq_wdata, vq_rdata;
  logic [AUX_W-1:0]     aq_rdata;

  logic pkt_fall, marker_go, vq_req, vq_push, vq_drop, aq_push, aq_drop;
  logic gnt_ok, gnt_v, gnt_a;

  assign pkt_fall  = pkt_en_q & ~bus.packet_en;
  // The marker shares the video queue's write slot, so it waits for a cycle
  // with no video word; this keeps it behind every word of its packet.
  assign marker_go = eop_pend & ~bus.vid_valid;
  assign vq_req    = bus.vid_valid | marker_go;
  assign vq_push   = vq_req & ~vq_full;
  assign vq_drop   = vq_req & vq_full;
  assign vq_wdata  = marker_go ? {1'b1, {(VID_W - PKT_CNT_W){1'b0}}, pkt_words}
                               : {1'b0, bus.vid_data};
  assign aq_push   = bus.aux_valid & ~aq_full;
  assign aq_drop   = bus.aux_valid & aq_full;

  assign gnt_ok = bus.arb_en & ~bus.fifo_full;
  assign gnt_v  = gnt_ok & ~vq_empty & (aq_empty | (vid_run < RUN_MAX));
  assign gnt_a  = gnt_ok & ~aq_empty & ~gnt_v;

  rx_arb_fifo #(.W(VQ_W), .AW(VQ_AW)) u_vq (
    .clk   (clk125),
    .rst_n (sys_rst_n),
    .push  (vq_push),
    .wdata (vq_wdata),
    .pop   (gnt_v),
    .rdata (vq_rdata),
    .full  (vq_full),
    .empty (vq_empty)
  );

  rx_arb_fifo #(.W(AUX_W), .AW(AQ_AW)) u_aq (
    .clk   (clk125),
    .rst_n (sys_rst_n),
    .push  (aq_push),
    .wdata (bus.aux_data),
    .pop   (gnt_a),
    .rdata (aq_rdata),
    .full  (aq_full),
    .empty (aq_empty)
  );

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_en_q       <= 1'b0;
      eop_pend       <= 1'b0;
      pkt_words      <= '0;
      vid_run        <= '0;
      bus.drop_cnt   <= '0;
      bus.overflow   <= 1'b0;
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_din   <= '0;
    end else begin
      pkt_en_q <= bus.packet_en;
      eop_pend <= (eop_pend & ~marker_go) | pkt_fall;

      // A marker attempt closes the packet whether it was queued or dropped.
      if (marker_go)    pkt_words <= '0;
      else if (vq_push) pkt_words <= pkt_words + 1'b1;

      bus.drop_cnt <= sat_add(bus.drop_cnt, {1'b0, vq_drop} + {1'b0, aq_drop});
      bus.overflow <= bus.overflow | vq_drop | aq_drop;

      if (gnt_v) begin
        if (vid_run != RUN_MAX) vid_run <= vid_run + 1'b1;
      end else if (gnt_a || vq_empty) begin
        vid_run <= '0;
      end

      bus.fifo_wr_en <= gnt_v | gnt_a;
      if (gnt_v)
        bus.fifo_din <= {vq_rdata[VID_W] ? TAG_EOP : TAG_VID, 1'b0, vq_rdata[VID_W-1:0]};
      else if (gnt_a)
        bus.fifo_din <= {TAG_AUX, {(PAYLOAD_W - AUX_W){1'b0}}, aq_rdata};
    end
  end

endmodule

// File: tb/tb_rx_wr_arbiter.sv
module tb_rx_wr_arbiter;

  logic clk125 = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk125 = ~clk125;

  rx_wr_arbiter_if bus ();

  rx_wr_arbiter #(.VQ_AW(3), .AQ_AW(4), .MAX_VID_RUN(4)) dut (
    .clk125    (clk125),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic        pe;
    logic        vv;
    logic [28:0] vd;
    logic        exp_wr;
    logic [31:0] exp_din;
  } vec_t;

  vec_t tbl [21];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] cap [$];

  always @(negedge clk125) begin
    if (bus.fifo_wr_en === 1'b1) cap.push_back(bus.fifo_din);
  end

  function automatic vec_t v(logic pe, logic vv, logic [28:0] vd, logic ew, logic [31:0] ed);
    vec_t r;
    r.pe = pe; r.vv = vv; r.vd = vd; r.exp_wr = ew; r.exp_din = ed;
    return r;
  endfunction

  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  function automatic logic [31:0] cap_at(int unsigned i);
    return (i < cap.size()) ? cap[i] : 32'hxxxx_xxxx;
  endfunction

  logic [31:0] exp2 [10];

  initial begin
    bus.arb_en = 1'b1; bus.vid_data = '0; bus.vid_valid = 1'b0; bus.packet_en = 1'b0;
    bus.aux_data = '0; bus.aux_valid = 1'b0; bus.fifo_full = 1'b0;

    // video packet of 6 words, then a packet whose last word coincides with packet_en falling
    tbl[0]  = v(1, 1, 29'h1ABC_0000, 0, 32'h0000_0000);
    tbl[1]  = v(1, 0, 29'h0,         1, 32'h1ABC_0000);
    tbl[2]  = v(1, 1, 29'h1ABC_0001, 0, 32'h1ABC_0000);
    tbl[3]  = v(1, 0, 29'h0,         1, 32'h1ABC_0001);
    tbl[4]  = v(1, 1, 29'h1ABC_0002, 0, 32'h1ABC_0001);
    tbl[5]  = v(1, 0, 29'h0,         1, 32'h1ABC_0002);
    tbl[6]  = v(1, 1, 29'h1ABC_0003, 0, 32'h1ABC_0002);
    tbl[7]  = v(1, 0, 29'h0,         1, 32'h1ABC_0003);
    tbl[8]  = v(1, 1, 29'h1ABC_0004, 0, 32'h1ABC_0003);
    tbl[9]  = v(1, 0, 29'h0,         1, 32'h1ABC_0004);
    tbl[10] = v(1, 1, 29'h1ABC_0005, 0, 32'h1ABC_0004);
    tbl[11] = v(0, 0, 29'h0,         1, 32'h1ABC_0005);
    tbl[12] = v(0, 0, 29'h0,         0, 32'h1ABC_0005);
    tbl[13] = v(0, 0, 29'h0,         1, 32'h8000_0006);
    tbl[14] = v(0, 0, 29'h0,         0, 32'h8000_0006);
    tbl[15] = v(1, 1, 29'h1ABC_0006, 0, 32'h8000_0006);
    tbl[16] = v(1, 0, 29'h0,         1, 32'h1ABC_0006);
    tbl[17] = v(0, 1, 29'h1ABC_0007, 0, 32'h1ABC_0006);
    tbl[18] = v(0, 0, 29'h0,         1, 32'h1ABC_0007);
    tbl[19] = v(0, 0, 29'h0,         1, 32'h8000_0002);
    tbl[20] = v(0, 0, 29'h0,         0, 32'h8000_0002);

    repeat (2) @(posedge clk125);
    #1;
    chk("rst_wr_en",    {39'd0, bus.fifo_wr_en}, 40'd0);
    chk("rst_din",      {8'd0, bus.fifo_din},    40'd0);
    chk("rst_drop_cnt", {32'd0, bus.drop_cnt},   40'd0);
    chk("rst_overflow", {39'd0, bus.overflow},   40'd0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      bus.packet_en = tbl[i].pe;
      bus.vid_valid = tbl[i].vv;
      bus.vid_data  = tbl[i].vd;
      tick();
      chk($sformatf("vec%0d", i), {7'd0, bus.fifo_wr_en, bus.fifo_din},
          {7'd0, tbl[i].exp_wr, tbl[i].exp_din});
    end

    // contention: 8 video and 2 aux queued while grants are held off
    cap.delete();
    bus.arb_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.vid_valid = 1'b1; bus.vid_data = 29'h0000_1100 + 29'(k);
      tick();
      bus.vid_valid = 1'b0;
      tick();
    end
    bus.aux_valid = 1'b1; bus.aux_data = 12'hA00; tick();
    bus.aux_data = 12'hA01; tick();
    bus.aux_valid = 1'b0; tick();
    chk("cont_no_wr_hold", {8'd0, 32'(cap.size())}, 40'd0);
    bus.arb_en = 1'b1;
    repeat (14) tick();
    exp2[0] = 32'h0000_1100; exp2[1] = 32'h0000_1101; exp2[2] = 32'h0000_1102;
    exp2[3] = 32'h0000_1103; exp2[4] = 32'h4000_0A00; exp2[5] = 32'h0000_1104;
    exp2[6] = 32'h0000_1105; exp2[7] = 32'h0000_1106; exp2[8] = 32'h0000_1107;
    exp2[9] = 32'h4000_0A01;
    chk("cont_count", {8'd0, 32'(cap.size())}, 40'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("cont_word%0d", i), {8'd0, cap_at(i)}, {8'd0, exp2[i]});

    // backpressure: 12 video words against a full downstream
    cap.delete();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.vid_valid = 1'b1; bus.vid_data = 29'h0000_2200 + 29'(k);
      tick();
      bus.vid_valid = 1'b0;
      tick();
    end
    chk("bp_no_wr",   {8'd0, 32'(cap.size())},  40'd0);
    chk("bp_drop",    {32'd0, bus.drop_cnt},    40'd4);
    chk("bp_overflow",{39'd0, bus.overflow},    40'd1);
    bus.fifo_full = 1'b0;
    repeat (12) tick();
    chk("bp_count", {8'd0, 32'(cap.size())}, 40'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_word%0d", i), {8'd0, cap_at(i)}, {8'd0, 32'h0000_2200 + 32'(i)});

    // arb_en gating: 3 aux words held, then released back-to-back
    cap.delete();
    bus.arb_en = 1'b0;
    bus.aux_valid = 1'b1; bus.aux_data = 12'h0B1; tick();
    bus.aux_data = 12'h0B2; tick();
    bus.aux_valid = 1'b0; tick();
    bus.aux_valid = 1'b1; bus.aux_data = 12'h0B3; tick();
    bus.aux_valid = 1'b0;
    repeat (4) tick();
    chk("gate_no_wr", {8'd0, 32'(cap.size())}, 40'd0);
    bus.arb_en = 1'b1;
    tick(); chk("gate_w0", {7'd0, bus.fifo_wr_en, bus.fifo_din}, {7'd0, 1'b1, 32'h4000_00B1});
    tick(); chk("gate_w1", {7'd0, bus.fifo_wr_en, bus.fifo_din}, {7'd0, 1'b1, 32'h4000_00B2});
    tick(); chk("gate_w2", {7'd0, bus.fifo_wr_en, bus.fifo_din}, {7'd0, 1'b1, 32'h4000_00B3});
    tick(); chk("gate_idle", {7'd0, bus.fifo_wr_en, bus.fifo_din}, {7'd0, 1'b0, 32'h4000_00B3});

    // reset in the middle of a drain with both queues partly filled
    bus.arb_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bus.vid_valid = (j % 2 == 0);
      bus.vid_data  = 29'h0000_3300 + 29'(j);
      bus.aux_valid = (j % 3 != 2);
      bus.aux_data  = 12'hC00 + 12'(j);
      tick();
    end
    bus.vid_valid = 1'b0; bus.aux_valid = 1'b0;
    bus.arb_en = 1'b1;
    tick();
    chk("mid_pre_wr", {39'd0, bus.fifo_wr_en}, 40'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_wr",   {39'd0, bus.fifo_wr_en}, 40'd0);
    chk("mid_rst_din",  {8'd0, bus.fifo_din},    40'd0);
    chk("mid_rst_drop", {32'd0, bus.drop_cnt},   40'd0);
    chk("mid_rst_ovf",  {39'd0, bus.overflow},   40'd0);
    @(posedge clk125);
    #2 sys_rst_n = 1'b1;
    cap.delete();
    repeat (20) tick();
    chk("post_rst_no_wr", {8'd0, 32'(cap.size())}, 40'd0);
    chk("post_rst_din",   {8'd0, bus.fifo_din},    40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
